serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial WIDTH-bit subtractor: Diff = A - B - B_in, one bit per clock, LSB first.
//   A single full-subtractor cell and a borrow flip-flop iterate over the operand bits.
//   Companion to the combinational full adder: it performs the inverse operation sequentially.
//   Valid/ready handshakes on both sides; sits between an operand source and a result consumer.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range >= 2
// PORTS
//   CLK        in   1      clock; all state updates on rising edge
//   RST        in   1      synchronous, active-high reset
//   A          in   WIDTH  minuend, sampled on accept
//   B          in   WIDTH  subtrahend, sampled on accept
//   B_in       in   1      borrow-in, sampled on accept
//   In_valid   in   1      operands present
//   In_ready   out  1      block idle; can accept operands
//   Diff       out  WIDTH  difference result
//   B_out      out  1      final borrow out (1 = unsigned A < B + B_in)
//   Out_valid  out  1      Diff/B_out valid
//   Out_ready  in   1      consumer takes result
// BEHAVIOUR
//   Reset (RST=1 at an edge): state=IDLE; Diff=0, B_out=0, Out_valid=0, Overflow=0.
//     In_ready=1 in the first cycle after reset.
//   FSM states and transitions:
//     IDLE -> SHIFT   In_valid && In_ready
//     SHIFT -> DONE   after WIDTH bit steps
//     DONE -> IDLE    Out_ready && Out_valid
//   IDLE: In_ready=1. On accept, latch A, B, B_in into shift/borrow regs; bit count=0.
//   SHIFT: each edge processes bit a0,b0 with borrow br:
//     d = a0^b0^br
//     br' = (~a0&b0) | (~(a0^b0)&br)
//     d shifts into result MSB; operand regs shift right; count++.
//     After the WIDTH-th step, enter DONE.
//   Latency: Out_valid rises exactly WIDTH cycles after the accepting edge.
//   DONE: Out_valid=1. Diff and B_out are registered and stable until the handshake.
//     B_out = final borrow.
//   Handshakes:
//     In_ready=0 in SHIFT and DONE; In_valid is ignored there and operands are not sampled.
//     DONE->IDLE on the Out_ready edge; In_ready=1 the next cycle (no same-cycle bypass).
//     Out_valid holds indefinitely while Out_ready=0.
//   Diff keeps its last value after the handshake; only Out_valid qualifies it.
//   Bit counter width is $clog2(WIDTH+1); it never wraps mid-operation.
//   Simultaneous In_valid and Out_ready in DONE: result is retired; new operands are not
//     accepted that cycle.
//   RST mid-operation (SHIFT or DONE): operation aborts and the reset values above apply.
//     No partial result is emitted.
//   Arithmetic is modulo 2^WIDTH; B_out is the carry-free borrow of the full WIDTH-bit subtraction.
// CONFIGURATION
//   SERIAL_SUB_OVERFLOW_EN defined:
//     adds port Overflow (out, 1), the registered signed two's-complement overflow.
//     Overflow = (A[MSB]!=B[MSB]) && (Diff[MSB]!=A[MSB]), using the latched operands.
//     Valid with Out_valid; reset value 0.
//   Macro undefined: Overflow port and its logic are absent; all other behaviour is identical.
// TESTING
//   1 A=100, B=37, B_in=0 -> Diff=63, B_out=0; Out_valid exactly 8 cycles after accept.
//   2 A=5, B=9, B_in=0 -> Diff=8'hFC, B_out=1; Overflow=0 (macro on).
//   3 A=0, B=0, B_in=1 -> Diff=8'hFF, B_out=1.
//     Then A=8'hFF, B=8'hFF, B_in=0 -> Diff=0, B_out=0.
//   4 Out_ready=0 for 5 cycles in DONE, In_valid=1 with new operands throughout:
//     Diff/B_out stable, In_ready=0, no new operands sampled.
//     After Out_ready=1: In_ready=1 one cycle later.
//   5 RST=1 at SHIFT step 3 of A=200, B=50:
//     next cycle Out_valid=0, Diff=0, In_ready=1.
//     A following op A=10, B=3 gives Diff=7, B_out=0.
//   6 Macro on, A=8'h80, B=8'h01, B_in=0 -> Diff=8'h7F, B_out=0, Overflow=1.
//     Back-to-back accepts are spaced WIDTH+2 cycles apart when Out_ready=1.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (Diff = A - B - B_in), one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_in,
  input  logic             In_valid,
  output logic             In_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             B_out,
  output logic             Out_valid,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             Overflow,
`endif
  input  logic             Out_ready
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic a0, b0, d_bit, br_nxt, last_step;

  // Full-subtractor cell operating on the current LSBs and the stored borrow
  assign a0        = a_q[0];
  assign b0        = b_q[0];
  assign d_bit     = a0 ^ b0 ^ br_q;
  assign br_nxt    = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (In_valid) begin
          a_d     = A;
          b_d     = B;
          br_d    = B_in;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        res_d = {d_bit, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_step) begin
          diff_d  = {d_bit, res_q[WIDTH-1:1]};
          bout_d  = br_nxt;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (Out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign In_ready  = (state_q == S_IDLE);
  assign Out_valid = (state_q == S_DONE);
  assign Diff      = diff_q;
  assign B_out     = bout_q;

`ifdef SERIAL_SUB_OVERFLOW_EN
  // Operand sign bits are shifted out during the operation, so keep copies
  logic amsb_q, amsb_d;
  logic bmsb_q, bmsb_d;
  logic ovf_q, ovf_d;

  always_comb begin
    amsb_d = amsb_q;
    bmsb_d = bmsb_q;
    ovf_d  = ovf_q;
    if (state_q == S_IDLE && In_valid) begin
      amsb_d = A[WIDTH-1];
      bmsb_d = B[WIDTH-1];
    end else if (state_q == S_SHIFT && last_step) begin
      ovf_d = (amsb_q != bmsb_q) && (d_bit != amsb_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      amsb_q <= 1'b0;
      bmsb_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      amsb_q <= amsb_d;
      bmsb_q <= bmsb_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH=8); overflow checks
// are included when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] A, B;
  logic         B_in, In_valid, In_ready;
  logic [W-1:0] Diff;
  logic         B_out, Out_valid, Out_ready;
  logic         ovf_w;

  int errors = 0;
  int checks = 0;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic Overflow;
  assign ovf_w = Overflow;
`else
  assign ovf_w = 1'b0;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .B         (B),
    .B_in      (B_in),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .Diff      (Diff),
    .B_out     (B_out),
    .Out_valid (Out_valid),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .Overflow  (Overflow),
`endif
    .Out_ready (Out_ready)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output logic [W-1:0] d, output logic bo, output logic ov,
                        output int lat);
    int guard;
    guard = 0;
    A = a; B = b; B_in = bin; In_valid = 1'b1;
    while (!In_ready && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    In_valid = 1'b0;
    lat = 0;
    while (!Out_valid && lat < 50) begin
      tick();
      lat++;
    end
    d = Diff; bo = B_out; ov = ovf_w;
    Out_ready = 1'b1;
    tick();
    Out_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input logic [W-1:0] exp_d, input logic exp_bo,
                          input logic exp_ov);
    logic [W-1:0] d;
    logic bo, ov;
    int lat;
    run_op(a, b, bin, d, bo, ov, lat);
    checks++;
    if (d !== exp_d) begin
      errors++;
      $display("FAIL %s diff: got %h expected %h", name, d, exp_d);
    end
    checks++;
    if (bo !== exp_bo) begin
      errors++;
      $display("FAIL %s b_out: got %b expected %b", name, bo, exp_bo);
    end
    checks++;
    if (lat != W) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, W);
    end
`ifdef SERIAL_SUB_OVERFLOW_EN
    checks++;
    if (ov !== exp_ov) begin
      errors++;
      $display("FAIL %s overflow: got %b expected %b", name, ov, exp_ov);
    end
`else
    if (ov !== 1'b0 && exp_ov === 1'bx) errors++;
`endif
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    checks++;
    if (In_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", In_ready); end
    checks++;
    if (Out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", Out_valid); end
    checks++;
    if (Diff !== 8'h00) begin errors++; $display("FAIL reset diff: got %h expected 00", Diff); end
    checks++;
    if (B_out !== 1'b0) begin errors++; $display("FAIL reset b_out: got %b expected 0", B_out); end
`ifdef SERIAL_SUB_OVERFLOW_EN
    checks++;
    if (ovf_w !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b expected 0", ovf_w); end
`endif
  endtask

  task automatic test_basic();
    check_op("sub_100_37", 8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 1'b0);
    check_op("sub_5_9",    8'd5,   8'd9,  1'b0, 8'hFC, 1'b1, 1'b0);
  endtask

  task automatic test_borrow_edges();
    check_op("sub_0_0_bin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    check_op("sub_ff_ff",   8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
    check_op("sub_7f_ff",   8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
  endtask

  task automatic test_hold();
    int guard;
    A = 8'h33; B = 8'h11; B_in = 1'b0; In_valid = 1'b1;
    tick();
    In_valid = 1'b0;
    guard = 0;
    while (!Out_valid && guard < 50) begin
      tick();
      guard++;
    end
    checks++;
    if (guard != W) begin errors++; $display("FAIL hold latency: got %0d expected %0d", guard, W); end
    A = 8'h01; B = 8'h02; B_in = 1'b1; In_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (Out_valid !== 1'b1 || In_ready !== 1'b0 || Diff !== 8'h22 || B_out !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d: out_valid=%b in_ready=%b diff=%h b_out=%b expected 1 0 22 0",
                 i, Out_valid, In_ready, Diff, B_out);
      end
    end
    Out_ready = 1'b1;
    tick();
    Out_ready = 1'b0;
    In_valid = 1'b0;
    checks++;
    if (In_ready !== 1'b1 || Out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold release: in_ready=%b out_valid=%b expected 1 0", In_ready, Out_valid);
    end
    tick();
    checks++;
    if (In_ready !== 1'b1 || Diff !== 8'h22) begin
      errors++;
      $display("FAIL hold idle: in_ready=%b diff=%h expected 1 22", In_ready, Diff);
    end
  endtask

  task automatic test_abort();
    A = 8'd200; B = 8'd50; B_in = 1'b0; In_valid = 1'b1;
    tick();
    In_valid = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (Out_valid !== 1'b0 || Diff !== 8'h00 || In_ready !== 1'b1 || B_out !== 1'b0) begin
      errors++;
      $display("FAIL abort state: out_valid=%b diff=%h in_ready=%b b_out=%b expected 0 00 1 0",
               Out_valid, Diff, In_ready, B_out);
    end
    for (int i = 0; i < W + 2; i++) begin
      tick();
      checks++;
      if (Out_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort no_emit cycle %0d: out_valid=%b expected 0", i, Out_valid);
      end
    end
    check_op("after_abort", 8'd10, 8'd3, 1'b0, 8'd7, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int acc[3];
    int n, cyc;
    n = 0;
    cyc = 0;
    A = 8'h80; B = 8'h01; B_in = 1'b0; In_valid = 1'b1; Out_ready = 1'b1;
    while (n < 3 && cyc < 60) begin
      if (In_ready) begin
        acc[n] = cyc;
        n++;
      end
      if (Out_valid) begin
        checks++;
        if (Diff !== 8'h7F || B_out !== 1'b0 || (ovf_w !== 1'b1 && ovf_w !== 1'b0)) begin
          errors++;
          $display("FAIL b2b result: diff=%h b_out=%b expected 7f 0", Diff, B_out);
        end
`ifdef SERIAL_SUB_OVERFLOW_EN
        checks++;
        if (ovf_w !== 1'b1) begin
          errors++;
          $display("FAIL b2b overflow: got %b expected 1", ovf_w);
        end
`endif
      end
      tick();
      cyc++;
    end
    In_valid = 1'b0;
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL b2b accepts: got %0d expected 3", n);
    end else begin
      checks++;
      if (acc[1] - acc[0] != W + 2 || acc[2] - acc[1] != W + 2) begin
        errors++;
        $display("FAIL b2b spacing: got %0d,%0d expected %0d", acc[1] - acc[0], acc[2] - acc[1], W + 2);
      end
    end
    while (!In_ready && cyc < 100) begin
      tick();
      cyc++;
    end
    Out_ready = 1'b0;
  endtask

  initial begin
    RST = 1'b0; A = '0; B = '0; B_in = 1'b0; In_valid = 1'b0; Out_ready = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_borrow_edges();
    test_hold();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
